arduino_xfer_ctrl: RTL and testbench

//  Sequences multi-byte transfers over the 8-bit Arduino port with a strobe/ack handshake.
//  CPU side latches a 32-bit word plus byte count; the block sends bytes LSB first.

---
 rtl/arduino_pkg.sv | 21 ++
 rtl/ard_sync.sv | 20 ++
 rtl/arduino_xfer_ctrl.sv | 129 ++++++++++++
 tb/tb_arduino_xfer_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arduino_pkg.sv
// Shared types and constants for the Arduino port transfer controller.
package arduino_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;

  localparam int unsigned DEF_SETUP_CYCLES   = 2;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    NEXT,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/ard_sync.sv
// Multi-flop synchroniser for the asynchronous Arduino ack line; resets to 0.
module ard_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/arduino_xfer_ctrl.sv
// Multi-byte strobe/ack transfer sequencer for the 8-bit Arduino port.
// Optional ack timeout enabled by defining ARDUINO_XFER_TIMEOUT_EN.
module arduino_xfer_ctrl
  import arduino_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  nbytes,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  output logic [BYTE_W-1:0] ard_data_out,
  output logic              ard_strb,
  input  logic              ard_ack,
  input  logic [BYTE_W-1:0] ard_data_in
);

  if (SETUP_CYCLES < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("arduino_xfer_ctrl: illegal timing parameters");
  end

`ifdef ARDUINO_XFER_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
`else
  localparam int unsigned CNT_MAX = SETUP_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  xfer_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nbytes_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ack_s;
  logic              wait_expired;
  logic              counting;

  ard_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ard_ack),
    .q     (ack_s)
  );

  // One counter serves both the setup delay and the ack-wait timeout;
  // it restarts on every state change.
`ifdef ARDUINO_XFER_TIMEOUT_EN
  assign wait_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign counting     = (state == SETUP) || (state == STROBE) || (state == RELEASE);
`else
  assign wait_expired = 1'b0;
  assign counting     = (state == SETUP);
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (cnt == CNT_W'(SETUP_CYCLES - 1)) state_next = STROBE;
      STROBE: begin
        if (ack_s)             state_next = RELEASE;
        else if (wait_expired) state_next = DONE;
      end
      RELEASE: begin
        if (!ack_s)            state_next = NEXT;
        else if (wait_expired) state_next = DONE;
      end
      NEXT:    state_next = (idx == nbytes_q) ? DONE : SETUP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      nbytes_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (counting)       cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: if (start) begin
          wdata_q  <= wdata;
          nbytes_q <= nbytes;
          rdata_q  <= '0;
          idx      <= '0;
        end
        STROBE: if (ack_s) rdata_q[BYTE_W*idx +: BYTE_W] <= ard_data_in;
        NEXT:   if (idx != nbytes_q) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ARDUINO_XFER_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (state == IDLE && start) err_q <= 1'b0;
    else if ((state == STROBE || state == RELEASE) && state_next == DONE) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Driven from the latched word, so the pins hold the last byte until the next SETUP.
  assign ard_data_out = wdata_q[BYTE_W*idx +: BYTE_W];
  assign rdata        = rdata_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign ard_strb     = (state == STROBE);

endmodule

// File: tb/tb_arduino_xfer_ctrl.sv
// Directed self-checking bench for arduino_xfer_ctrl with a behavioural Arduino responder.
module tb_arduino_xfer_ctrl;

  localparam int unsigned SETUP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wdata = '0;
  logic [1:0]  nbytes = '0;
  logic        busy, done, err, ard_strb;
  logic [31:0] rdata;
  logic [7:0]  ard_data_out;
  logic        ard_ack = 1'b0;
  logic [7:0]  ard_data_in = '0;

  int errors = 0;
  int checks = 0;

  // responder modes: 0 fixed byte, 1 echo data_out+1, 2 never ack, 3 ack sticks high
  int         resp_mode = 0;
  int         resp_delay = 3;
  logic [7:0] resp_byte = '0;

  int         strb_cnt = 0;
  int         done_cnt = 0;
  int         strb_hi_cycles = 0;
  int         stable = 0;
  logic [7:0] sent [8];
  int         gap [8];
  logic       prev_strb = 1'b0;
  logic [7:0] prev_dout = '0;

  arduino_xfer_ctrl #(
    .SETUP_CYCLES   (SETUP),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .wdata        (wdata),
    .nbytes       (nbytes),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .ard_data_out (ard_data_out),
    .ard_strb     (ard_strb),
    .ard_ack      (ard_ack),
    .ard_data_in  (ard_data_in)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ard_data_out !== prev_dout) stable = 0;
    else stable = stable + 1;
    if (ard_strb && !prev_strb) begin
      if (strb_cnt < 8) begin
        sent[strb_cnt] = ard_data_out;
        gap[strb_cnt]  = stable;
      end
      strb_cnt = strb_cnt + 1;
    end
    if (ard_strb) strb_hi_cycles = strb_hi_cycles + 1;
    if (done) done_cnt = done_cnt + 1;
    prev_strb = ard_strb;
    prev_dout = ard_data_out;
  end

  initial begin
    forever begin
      @(posedge ard_strb);
      if (resp_mode == 2) continue;
      repeat (resp_delay) @(posedge clk);
      #1;
      ard_data_in = (resp_mode == 1) ? ard_data_out + 8'd1 : resp_byte;
      ard_ack = 1'b1;
      if (resp_mode == 3) continue;
      wait (!ard_strb);
      @(posedge clk);
      #1 ard_ack = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    strb_cnt = 0;
    done_cnt = 0;
    strb_hi_cycles = 0;
  endtask

  task automatic pulse_start(input logic [31:0] w, input logic [1:0] n);
    wdata = w;
    nbytes = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (ard_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", ard_data_out); end
    checks++; if (ard_strb !== 1'b0) begin errors++; $display("FAIL reset_strb: got %b expected 0", ard_strb); end
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_single_byte();
    bit ok;
    clear_counts();
    resp_mode = 0;
    resp_byte = 8'h3C;
    resp_delay = 3;
    pulse_start(32'h0000_00A5, 2'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done_seen: got %b expected 1", ok); end
    step();
    step();
    checks++; if (sent[0] !== 8'hA5) begin errors++; $display("FAIL single_data_out: got %h expected a5", sent[0]); end
    checks++; if (rdata !== 32'h0000_003C) begin errors++; $display("FAIL single_rdata: got %h expected 0000003c", rdata); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (strb_cnt !== 1) begin errors++; $display("FAIL single_strb_pulses: got %0d expected 1", strb_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    checks++; if (ard_data_out !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h expected a5", ard_data_out); end
  endtask

  task automatic test_four_bytes();
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    clear_counts();
    resp_mode = 1;
    resp_delay = 2;
    pulse_start(32'h1122_3344, 2'd3);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL four_done_seen: got %b expected 1", ok); end
    step();
    step();
    checks++; if (strb_cnt !== 4) begin errors++; $display("FAIL four_strb_pulses: got %0d expected 4", strb_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sent[i] !== exp_b[i]) begin errors++; $display("FAIL four_byte%0d: got %h expected %h", i, sent[i], exp_b[i]); end
      checks++; if (gap[i] !== SETUP) begin errors++; $display("FAIL four_setup%0d: got %0d expected %0d", i, gap[i], SETUP); end
    end
    checks++; if (rdata !== 32'h1223_3445) begin errors++; $display("FAIL four_rdata: got %h expected 12233445", rdata); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL four_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (ard_data_out !== 8'h11) begin errors++; $display("FAIL four_hold: got %h expected 11", ard_data_out); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    bit seen;
    clear_counts();
    resp_mode = 0;
    resp_byte = 8'h5A;
    resp_delay = 4;
    pulse_start(32'h0000_00C3, 2'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ard_strb === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ign_strobe_seen: got %b expected 1", seen); end
    pulse_start(32'hFFFF_FFFF, 2'd3);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_done_seen: got %b expected 1", ok); end
    pulse_start(32'hFFFF_FFFF, 2'd3);
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 32'h0000_005A) begin errors++; $display("FAIL ign_rdata: got %h expected 0000005a", rdata); end
    checks++; if (ard_data_out !== 8'hC3) begin errors++; $display("FAIL ign_data_out: got %h expected c3", ard_data_out); end
    checks++; if (strb_cnt !== 1) begin errors++; $display("FAIL ign_strb_pulses: got %0d expected 1", strb_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit seen;
    clear_counts();
    resp_mode = 1;
    resp_delay = 3;
    pulse_start(32'hAABB_CCDD, 2'd3);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (strb_cnt == 2 && ard_strb === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_byte2_seen: got %b expected 1", seen); end
    rst_n = 1'b0;
    #1;
    checks++; if (ard_strb !== 1'b0) begin errors++; $display("FAIL abort_strb: got %b expected 0", ard_strb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 00000000", rdata); end
    checks++; if (ard_data_out !== 8'h00) begin errors++; $display("FAIL abort_data_out: got %h expected 00", ard_data_out); end
    step();
    step();
    step();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    rst_n = 1'b1;
    step();
    step();
    step();
    clear_counts();
    resp_mode = 0;
    resp_byte = 8'h77;
    pulse_start(32'h0000_0012, 2'd0);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_recover_done: got %b expected 1", ok); end
    step();
    checks++; if (rdata !== 32'h0000_0077) begin errors++; $display("FAIL abort_recover_rdata: got %h expected 00000077", rdata); end
    checks++; if (sent[0] !== 8'h12) begin errors++; $display("FAIL abort_recover_data_out: got %h expected 12", sent[0]); end
  endtask

`ifdef ARDUINO_XFER_TIMEOUT_EN
  task automatic test_timeout_no_ack();
    bit ok;
    clear_counts();
    resp_mode = 2;
    pulse_start(32'h0000_005E, 2'd0);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done_seen: got %b expected 1", ok); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err); end
    checks++; if (strb_hi_cycles !== 100) begin errors++; $display("FAIL to_strb_len: got %0d expected 100", strb_hi_cycles); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL to_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (ard_strb !== 1'b0) begin errors++; $display("FAIL to_strb_low: got %b expected 0", ard_strb); end
    clear_counts();
    resp_mode = 0;
    resp_byte = 8'h01;
    pulse_start(32'h0000_0002, 2'd0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", err); end
    wait_done(ok);
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_after: got %b expected 0", err); end
  endtask

  task automatic test_timeout_stuck_ack();
    bit ok;
    clear_counts();
    resp_mode = 3;
    resp_byte = 8'h42;
    resp_delay = 2;
    pulse_start(32'h0000_BBAA, 2'd1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stuck_done_seen: got %b expected 1", ok); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_err: got %b expected 1", err); end
    checks++; if (rdata !== 32'h0000_0042) begin errors++; $display("FAIL stuck_rdata: got %h expected 00000042", rdata); end
    checks++; if (strb_cnt !== 1) begin errors++; $display("FAIL stuck_strb_pulses: got %0d expected 1", strb_cnt); end
    ard_ack = 1'b0;
    resp_mode = 0;
    repeat (4) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_four_bytes();
    test_start_ignored();
    test_reset_abort();
`ifdef ARDUINO_XFER_TIMEOUT_EN
    test_timeout_no_ack();
    test_timeout_stuck_ack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
